// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// FSM controller for a multicycle MIPS datapath. It sequences each instruction
// through the shared memory and ALU over 3-5 cycles. Every mem_ready=0 cycle in
// FETCH, MEMRD or MEMWR adds one cycle. The unit also flags illegal opcodes and
// functs, and it counts retired instructions.
//
// Parameters
//   ALU_CTRL_W   width of alu_control (>= 4); 4-bit ALU codes are zero-extended
//   ENABLE_ADDI  1: addi (001000) is decoded; 0: addi is illegal
//   ENABLE_JUMP  1: j (000010) is decoded; 0: j is illegal
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   op, funct             instruction fields from the instruction register
//   zero                  ALU zero flag (gates pc_en in BRANCH)
//   mem_ready             memory access completes this cycle
//   iord .. pc_src        datapath mux selects and write enables
//   alu_control           AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
//   illegal_op            one-cycle pulse when an undecodable instruction is seen
//   instr_count           retired-instruction counter, wraps
//   state                 current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter bit          ENABLE_ADDI = 1'b1,
  parameter bit          ENABLE_JUMP = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  reg_dst,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            pc_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      instr_count,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;

  // Raw decoded strobes. They are gated with rst_n before they leave the block.
  logic       ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;
  logic       pc_write, branch, retire;
  logic [3:0] alu_code;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d       = S_FETCH;
    iord          = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_code      = ALU_ADD;
    illegal_raw   = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    retire        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = mem_ready;
        pc_write     = mem_ready;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI: begin
            if (ENABLE_ADDI) state_d = S_ADDIEX;
            else             illegal_raw = 1'b1;
          end
          OP_J: begin
            if (ENABLE_JUMP) state_d = S_JUMP;
            else             illegal_raw = 1'b1;
          end
          default: illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // op is held stable, so only lw/sw can reach this state.
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        retire        = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
        retire        = mem_ready;
        state_d       = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_ALUWB;
        case (funct)
          F_ADD: alu_code = ALU_ADD;
          F_SUB: alu_code = ALU_SUB;
          F_AND: alu_code = ALU_AND;
          F_OR:  alu_code = ALU_OR;
          F_SLT: alu_code = ALU_SLT;
          default: begin
            // The write-back is skipped, so the bad instruction never retires.
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
        retire        = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: begin
        // Encodings 12-15 are unreachable. Drive everything quiet and recover.
        alu_code = 4'b0000;
      end
    endcase
  end

  // Reset suppresses every strobe combinationally. FETCH would otherwise
  // raise ir_write/pc_en from mem_ready while rst_n is still low.
  assign ir_write    = ir_write_raw & rst_n;
  assign pc_en       = (pc_write | (branch & zero)) & rst_n;
  assign mem_write   = mem_write_raw & rst_n;
  assign reg_write   = reg_write_raw & rst_n;
  assign illegal_op  = illegal_raw & rst_n;
  assign alu_control = ALU_CTRL_W'(alu_code);
  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. dut uses the default parameters.
// dut2 uses ENABLE_JUMP=0 and CNT_W=4, and it has its own inputs and reset.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut (defaults)
  logic        rst_n, zero, mem_ready;
  logic [5:0]  op, funct;
  logic        iord, ir_write, pc_en, mem_write, reg_write, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_control, state;
  logic        illegal_op;
  logic [31:0] instr_count;

  // dut2 (no jump, 4-bit counter)
  logic        rst2_n, zero2, mem_ready2;
  logic [5:0]  op2, funct2;
  logic        iord2, ir_write2, pc_en2, mem_write2, reg_write2, mem_to_reg2, reg_dst2, alu_src_a2;
  logic [1:0]  alu_src_b2, pc_src2;
  logic [3:0]  alu_control2, state2;
  logic        illegal_op2;
  logic [3:0]  instr_count2;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_control(alu_control), .illegal_op(illegal_op), .instr_count(instr_count),
    .state(state)
  );

  multicycle_control_unit #(.ENABLE_JUMP(1'b0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .op(op2), .funct(funct2), .zero(zero2), .mem_ready(mem_ready2),
    .iord(iord2), .ir_write(ir_write2), .pc_en(pc_en2), .mem_write(mem_write2),
    .reg_write(reg_write2), .mem_to_reg(mem_to_reg2), .reg_dst(reg_dst2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .pc_src(pc_src2),
    .alu_control(alu_control2), .illegal_op(illegal_op2), .instr_count(instr_count2),
    .state(state2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction with mem_ready=1. Check the state in each cycle.
  // seq holds up to five expected state nibbles, the first in [19:16].
  task automatic run_seq(input string tag, input logic [5:0] o, input logic [5:0] f,
                         input int n, input logic [19:0] seq);
    op    = o;
    funct = f;
    #1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_st%0d", tag, i), 32'(state), 32'(seq[19-4*i -: 4]));
      tick();
    end
  endtask

  logic [5:0] r_funct [4] = '{6'h22, 6'h24, 6'h25, 6'h2a};
  logic [3:0] r_alu   [4] = '{4'h6, 4'h0, 4'h1, 4'h7};
  logic       st_mr   [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
  logic [3:0] st_exp  [10] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4};
  logic       st_irw  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    rst_n = 1'b0; op = 6'h0; funct = 6'h0; zero = 1'b0; mem_ready = 1'b1;
    rst2_n = 1'b0; op2 = 6'h0; funct2 = 6'h0; zero2 = 1'b0; mem_ready2 = 1'b1;

    // Reset values. mem_ready=1 must not leak through to the write enables.
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_ir_write", 32'(ir_write), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_alu_src_b", 32'(alu_src_b), 32'd1);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    rst_n = 1'b1;
    #1;
    check("fetch_ir_write", 32'(ir_write), 32'd1);

    // Basic mix with mem_ready=1: 5+4+4+3+4+3 = 23 cycles, 6 retired.
    run_seq("lw",   6'h23, 6'h00, 5, 20'h01234);
    run_seq("sw",   6'h2b, 6'h00, 4, 20'h01250);
    run_seq("add",  6'h00, 6'h20, 4, 20'h01670);
    zero = 1'b1;
    run_seq("beq",  6'h04, 6'h00, 3, 20'h01800);
    zero = 1'b0;
    run_seq("addi", 6'h08, 6'h00, 4, 20'h019a0);
    run_seq("j",    6'h02, 6'h00, 3, 20'h01b00);
    check("count_after_mix", instr_count, 32'd6);

    // R-type ALU decoding: sub, and, or, slt.
    for (int k = 0; k < 4; k++) begin
      op = 6'h00; funct = r_funct[k];
      #1;
      tick();
      tick();
      check($sformatf("r%0d_exec", k), 32'(state), 32'd6);
      check($sformatf("r%0d_alu", k), 32'(alu_control), 32'(r_alu[k]));
      tick();
      check($sformatf("r%0d_wb_regdst", k), 32'(reg_dst), 32'd1);
      tick();
    end
    check("count_after_r", instr_count, 32'd10);

    // beq: pc_en follows zero combinationally in BRANCH.
    op = 6'h04;
    #1;
    tick(); tick();
    check("beq_state", 32'(state), 32'd8);
    zero = 1'b0;
    #1;
    check("beq_z0_pc_en", 32'(pc_en), 32'd0);
    zero = 1'b1;
    #1;
    check("beq_z1_pc_en", 32'(pc_en), 32'd1);
    check("beq_pc_src", 32'(pc_src), 32'd1);
    check("beq_alu", 32'(alu_control), 32'd6);
    tick();
    zero = 1'b0;
    check("count_after_beq", instr_count, 32'd11);

    // lw with 3 FETCH waits and 2 MEMRD waits takes 10 cycles.
    op = 6'h23;
    for (int i = 0; i < 10; i++) begin
      mem_ready = st_mr[i];
      #1;
      check($sformatf("lws_st%0d", i), 32'(state), 32'(st_exp[i]));
      check($sformatf("lws_irw%0d", i), 32'(ir_write), 32'(st_irw[i]));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lws_back_fetch", 32'(state), 32'd0);
    check("count_after_lws", instr_count, 32'd12);

    // Illegal opcode in DECODE, then illegal funct in EXEC.
    op = 6'h3f;
    #1;
    tick();
    check("ill_op_decode", 32'(illegal_op), 32'd1);
    tick();
    check("ill_op_fetch", 32'(state), 32'd0);
    check("ill_op_clear", 32'(illegal_op), 32'd0);
    op = 6'h00; funct = 6'h07;
    #1;
    tick();
    check("ill_fn_decode", 32'(illegal_op), 32'd0);
    tick();
    check("ill_fn_exec", 32'(illegal_op), 32'd1);
    check("ill_fn_alu", 32'(alu_control), 32'd2);
    tick();
    check("ill_fn_fetch", 32'(state), 32'd0);
    check("count_after_ill", instr_count, 32'd12);

    // sw stalled in MEMWR: mem_write stays high and nothing retires until exit.
    op = 6'h2b;
    #1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    check("sws_state", 32'(state), 32'd5);
    check("sws_mw0", 32'(mem_write), 32'd1);
    check("sws_count_hold", instr_count, 32'd12);
    tick();
    check("sws_mw1", 32'(mem_write), 32'd1);
    mem_ready = 1'b1;
    #1;
    check("sws_mw2", 32'(mem_write), 32'd1);
    tick();
    check("sws_fetch", 32'(state), 32'd0);
    check("sws_mw_off", 32'(mem_write), 32'd0);
    check("count_after_sws", instr_count, 32'd13);

    // Reset dropped mid-lw while in MEMRD.
    op = 6'h23;
    #1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    check("mid_memrd", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_count", instr_count, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("mid_rst_ir_write", 32'(ir_write), 32'd0);
    check("mid_rst_pc_en", 32'(pc_en), 32'd0);
    check("mid_rst_alu_src_b", 32'(alu_src_b), 32'd1);
    rst_n = 1'b1;

    // dut2: j is illegal, and the 4-bit counter wraps.
    op2 = 6'h02;
    tick();
    rst2_n = 1'b1;
    #1;
    check("d2_fetch", 32'(state2), 32'd0);
    tick();
    check("d2_j_decode", 32'(state2), 32'd1);
    check("d2_j_illegal", 32'(illegal_op2), 32'd1);
    tick();
    check("d2_j_fetch", 32'(state2), 32'd0);
    check("d2_j_count", 32'(instr_count2), 32'd0);
    op2 = 6'h04;
    for (int i = 0; i < 17; i++) begin
      tick(); tick(); tick();
      if (i == 15) check("d2_wrap16", 32'(instr_count2), 32'd0);
    end
    check("d2_count17", 32'(instr_count2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
